ex_stage_mc: RTL and testbench

- Parametrised execute stage for the 5-stage pipeline, sitting between the ID/EX register and the EX/MEM register.
- Resolves operand hazards by forwarding from EX/MEM and MEM/WB.
- Executes single-cycle ALU ops and iterative multi-cycle MUL/DIVU/REMU.
- Uses a valid/ready handshake on both sides, so the stage can hold the front end while busy and absorb back-pressure from MEM.

---
 rtl/ex_stage_mc.sv | 224 ++++++++++++++++++++++
 tb/tb_ex_stage_mc.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_mc.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage_mc
// Description : Execute stage with EX/MEM and MEM/WB operand forwarding,
//               single-cycle ALU and iterative MUL/DIVU/REMU, valid/ready
//               handshake towards ID/EX and MEM.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage_mc #(
    parameter int XLEN      = 32,
    parameter int RW        = 5,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_rs_val,
    input  logic [XLEN-1:0] in_rt_val,
    input  logic [XLEN-1:0] in_imm,
    input  logic [RW-1:0]   in_rs,
    input  logic [RW-1:0]   in_rt,
    input  logic [RW-1:0]   in_rd,
    input  logic            in_alu_src,
    input  logic            in_reg_dst,
    input  logic [3:0]      in_ctrl,
    input  logic [RW-1:0]   exm_rd,
    input  logic [RW-1:0]   wb_rd,
    input  logic            exm_we,
    input  logic            wb_we,
    input  logic [XLEN-1:0] exm_data,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_store,
    output logic [RW-1:0]   out_dest,
    output logic [3:0]      out_ctrl,
    output logic            out_illegal,
    output logic            busy
);

    localparam int         c_SH_W    = $clog2(XLEN);
    localparam int         c_CNT_W   = $clog2(XLEN + 1);
    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_AND  = 4'd2;
    localparam logic [3:0] c_OP_OR   = 4'd3;
    localparam logic [3:0] c_OP_XOR  = 4'd4;
    localparam logic [3:0] c_OP_SLT  = 4'd5;
    localparam logic [3:0] c_OP_SLL  = 4'd6;
    localparam logic [3:0] c_OP_SRL  = 4'd7;
    localparam logic [3:0] c_OP_MUL  = 4'd8;
    localparam logic [3:0] c_OP_DIVU = 4'd9;
    localparam logic [3:0] c_OP_REMU = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]     r_x;       // multiplicand (MUL) or divisor (DIV)
    logic [XLEN-1:0]     r_y;       // multiplier (MUL) or dividend/quotient shifter (DIV)
    logic [XLEN-1:0]     r_acc;     // partial product (MUL) or partial remainder (DIV)
    logic                r_is_rem;

    logic [XLEN-1:0]     w_a;
    logic [XLEN-1:0]     w_rt;
    logic [XLEN-1:0]     w_b;
    logic [XLEN-1:0]     w_alu;
    logic                w_accept;
    logic                w_is_md;
    logic                w_illegal;
    logic                w_last;
    logic [XLEN-1:0]     w_mul_acc;
    logic [XLEN:0]       w_shift;
    logic [XLEN:0]       w_diff;
    logic                w_qbit;
    logic [XLEN-1:0]     w_rem_nxt;
    logic [XLEN-1:0]     w_quo_nxt;

    // Forwarding: the newer EX/MEM value wins over MEM/WB; r0 is never forwarded.
    always_comb begin
        w_a = in_rs_val;
        if (exm_we && (exm_rd == in_rs) && (in_rs != '0)) begin
            w_a = exm_data;
        end else if (wb_we && (wb_rd == in_rs) && (in_rs != '0)) begin
            w_a = wb_data;
        end
        w_rt = in_rt_val;
        if (exm_we && (exm_rd == in_rt) && (in_rt != '0)) begin
            w_rt = exm_data;
        end else if (wb_we && (wb_rd == in_rt) && (in_rt != '0)) begin
            w_rt = wb_data;
        end
    end

    assign w_b       = in_alu_src ? in_imm : w_rt;
    assign in_ready  = (r_state == S_IDLE) && (!out_valid || out_ready);
    assign busy      = (r_state != S_IDLE);
    assign w_accept  = in_valid && in_ready;
    assign w_is_md   = MULDIV_EN && ((in_op == c_OP_MUL) || (in_op == c_OP_DIVU) || (in_op == c_OP_REMU));
    assign w_illegal = (in_op > c_OP_REMU) || (!MULDIV_EN && (in_op >= c_OP_MUL));
    assign w_last    = (r_cnt == c_CNT_W'(1));

    always_comb begin
        w_alu = '0;
        case (in_op)
            c_OP_ADD: w_alu = w_a + w_b;
            c_OP_SUB: w_alu = w_a - w_b;
            c_OP_AND: w_alu = w_a & w_b;
            c_OP_OR:  w_alu = w_a | w_b;
            c_OP_XOR: w_alu = w_a ^ w_b;
            c_OP_SLT: w_alu = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            c_OP_SLL: w_alu = w_a << w_b[c_SH_W-1:0];
            c_OP_SRL: w_alu = w_a >> w_b[c_SH_W-1:0];
            default:  w_alu = '0;
        endcase
    end

    // One shift-add step and one restoring-division step per cycle.
    assign w_mul_acc = r_acc + (r_y[0] ? r_x : '0);
    assign w_shift   = {1'b0, r_acc, r_y[XLEN-1]};
    assign w_diff    = w_shift - {1'b0, r_x};
    assign w_qbit    = !w_diff[XLEN];
    assign w_rem_nxt = w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign w_quo_nxt = {r_y[XLEN-2:0], w_qbit};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_md) begin
                    w_state_nxt = (in_op == c_OP_MUL) ? S_MUL : S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_acc       <= '0;
            r_is_rem    <= 1'b0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_store   <= '0;
            out_dest    <= '0;
            out_ctrl    <= '0;
            out_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        out_store <= w_rt;
                        out_dest  <= in_reg_dst ? in_rd : in_rt;
                        if (w_is_md) begin
                            out_valid   <= 1'b0;
                            out_ctrl    <= in_ctrl;
                            out_illegal <= 1'b0;
                            r_cnt       <= c_CNT_W'(XLEN);
                            r_x         <= (in_op == c_OP_MUL) ? w_a : w_b;
                            r_y         <= (in_op == c_OP_MUL) ? w_b : w_a;
                            r_acc       <= '0;
                            r_is_rem    <= (in_op == c_OP_REMU);
                        end else begin
                            out_valid   <= 1'b1;
                            out_result  <= w_alu;
                            out_ctrl    <= w_illegal ? 4'b0000 : in_ctrl;
                            out_illegal <= w_illegal;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_acc;
                    r_x   <= r_x << 1;
                    r_y   <= r_y >> 1;
                    r_cnt <= r_cnt - c_CNT_W'(1);
                    if (w_last) begin
                        out_result <= w_mul_acc;
                        out_valid  <= 1'b1;
                    end
                end
                S_DIV: begin
                    r_acc <= w_rem_nxt;
                    r_y   <= w_quo_nxt;
                    r_cnt <= r_cnt - c_CNT_W'(1);
                    if (w_last) begin
                        out_result <= r_is_rem ? w_rem_nxt : w_quo_nxt;
                        out_valid  <= 1'b1;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_stage_mc
// Description : Self-checking bench for ex_stage_mc: directed vector table,
//               multi-cycle/back-pressure/reset sequences, random traffic
//               against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage_mc;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_alu_src, in_reg_dst, exm_we, wb_we, out_ready;
    logic [3:0]  in_op, in_ctrl;
    logic [31:0] in_rs_val, in_rt_val, in_imm, exm_data, wb_data;
    logic [4:0]  in_rs, in_rt, in_rd, exm_rd, wb_rd;
    logic        in_ready, out_valid, out_illegal, busy;
    logic [31:0] out_result, out_store;
    logic [4:0]  out_dest;
    logic [3:0]  out_ctrl;
    logic        d2_in_ready, d2_out_valid, d2_out_illegal, d2_busy;
    logic [31:0] d2_out_result, d2_out_store;
    logic [4:0]  d2_out_dest;
    logic [3:0]  d2_out_ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_stage_mc #(.XLEN(32), .RW(5), .MULDIV_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm), .in_rs(in_rs),
        .in_rt(in_rt), .in_rd(in_rd), .in_alu_src(in_alu_src), .in_reg_dst(in_reg_dst),
        .in_ctrl(in_ctrl), .exm_rd(exm_rd), .wb_rd(wb_rd), .exm_we(exm_we), .wb_we(wb_we),
        .exm_data(exm_data), .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_store(out_store), .out_dest(out_dest),
        .out_ctrl(out_ctrl), .out_illegal(out_illegal), .busy(busy)
    );

    ex_stage_mc #(.XLEN(32), .RW(5), .MULDIV_EN(1'b0)) dut_nomd (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d2_in_ready), .in_op(in_op),
        .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm), .in_rs(in_rs),
        .in_rt(in_rt), .in_rd(in_rd), .in_alu_src(in_alu_src), .in_reg_dst(in_reg_dst),
        .in_ctrl(in_ctrl), .exm_rd(exm_rd), .wb_rd(wb_rd), .exm_we(exm_we), .wb_we(wb_we),
        .exm_data(exm_data), .wb_data(wb_data), .out_valid(d2_out_valid), .out_ready(out_ready),
        .out_result(d2_out_result), .out_store(d2_out_store), .out_dest(d2_out_dest),
        .out_ctrl(d2_out_ctrl), .out_illegal(d2_out_illegal), .busy(d2_busy)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, imm;
        logic        src;
        logic [4:0]  rs, rt, rd;
        logic        rdst;
        logic [3:0]  ctrl;
        logic        ewe, wwe;
        logic [4:0]  erd, wrd;
        logic [31:0] ed, wd;
        logic [31:0] er, es;
        logic        ill;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: the stage holds at most one transaction, either counting
    // down its multi-cycle latency or sitting in the output slot.
    int          m_busy;
    bit          m_valid, m_ill, p_ill;
    logic [31:0] m_res, m_st, p_res, p_st;
    logic [4:0]  m_dest, p_dest;
    logic [3:0]  m_ctrl, p_ctrl;

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 5'd0) return rf;
        if (exm_we && exm_rd == idx) return exm_data;
        if (wb_we && wb_rd == idx) return wb_data;
        return rf;
    endfunction

    function automatic logic [31:0] ref_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: return a << b[4:0];
            4'd7: return a >> b[4:0];
            4'd8: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            4'd9: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd10: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 0; m_valid = 0;
    endtask

    task automatic model_check();
        bit rdy;
        rdy = (m_busy == 0) && (!m_valid || out_ready);
        chk("model in_ready", in_ready, rdy);
        chk("model busy", busy, m_busy > 0);
        chk("model out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("model out_result", out_result, m_res);
            chk("model out_store", out_store, m_st);
            chk("model out_dest", out_dest, m_dest);
            chk("model out_ctrl", out_ctrl, m_ctrl);
            chk("model out_illegal", out_illegal, m_ill);
        end
    endtask

    task automatic model_step();
        bit rdy, ill;
        logic [31:0] a, rt, b;
        rdy = (m_busy == 0) && (!m_valid || out_ready);
        if (rst) begin
            model_reset();
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_valid = 1; m_res = p_res; m_st = p_st; m_dest = p_dest; m_ctrl = p_ctrl; m_ill = p_ill;
            end
        end else begin
            if (m_valid && out_ready) m_valid = 0;
            if (in_valid && rdy) begin
                a   = fwd(in_rs, in_rs_val);
                rt  = fwd(in_rt, in_rt_val);
                b   = in_alu_src ? in_imm : rt;
                ill = (in_op > 4'd10);
                p_res = ref_exec(in_op, a, b); p_st = rt; p_dest = in_reg_dst ? in_rd : in_rt;
                p_ctrl = ill ? 4'd0 : in_ctrl; p_ill = ill;
                if (in_op >= 4'd8 && in_op <= 4'd10) begin
                    m_busy = XLEN;
                end else begin
                    m_valid = 1; m_res = p_res; m_st = p_st; m_dest = p_dest; m_ctrl = p_ctrl; m_ill = p_ill;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] imm, input logic src, input logic [31:0] er,
                                input logic [31:0] es, input logic ill, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.imm = imm; v.src = src;
        v.rs = 5'd1; v.rt = 5'd2; v.rd = 5'd7; v.rdst = 1'b1; v.ctrl = 4'b1010;
        v.ewe = 0; v.wwe = 0; v.erd = 0; v.wrd = 0; v.ed = 0; v.wd = 0;
        v.er = er; v.es = es; v.ill = ill; v.lat = lat;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        in_op = v.op; in_rs_val = v.a; in_rt_val = v.b; in_imm = v.imm; in_alu_src = v.src;
        in_rs = v.rs; in_rt = v.rt; in_rd = v.rd; in_reg_dst = v.rdst; in_ctrl = v.ctrl;
        exm_we = v.ewe; exm_rd = v.erd; exm_data = v.ed; wb_we = v.wwe; wb_rd = v.wrd; wb_data = v.wd;
    endtask

    vec_t vt[19];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n, bcnt, r;
        vec_t v;

        vt[0]  = mk(4'd0, 32'd5, 32'd0, 32'd7, 1'b1, 32'd12, 32'd0, 1'b0, 1);
        vt[1]  = mk(4'd1, 32'd3, 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFE, 32'd5, 1'b0, 1);
        vt[2]  = mk(4'd2, 32'hF0F0, 32'hFF00, 32'd0, 1'b0, 32'hF000, 32'hFF00, 1'b0, 1);
        vt[3]  = mk(4'd3, 32'h0F0F, 32'hF000, 32'd0, 1'b0, 32'hFF0F, 32'hF000, 1'b0, 1);
        vt[4]  = mk(4'd4, 32'hFFFF, 32'h0F0F, 32'd0, 1'b0, 32'hF0F0, 32'h0F0F, 1'b0, 1);
        vt[5]  = mk(4'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'd1, 32'd1, 1'b0, 1);
        vt[6]  = mk(4'd5, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
        vt[6].rdst = 1'b0;
        vt[7]  = mk(4'd6, 32'd1, 32'd33, 32'd0, 1'b0, 32'd2, 32'd33, 1'b0, 1);
        vt[8]  = mk(4'd7, 32'h8000_0000, 32'h55, 32'd4, 1'b1, 32'h0800_0000, 32'h55, 1'b0, 1);
        vt[9]  = mk(4'd0, 32'd1, 32'd9, 32'd0, 1'b1, 32'hAA, 32'd9, 1'b0, 1);
        vt[9].rs = 5'd3; vt[9].ewe = 1; vt[9].erd = 5'd3; vt[9].ed = 32'hAA;
        vt[9].wwe = 1; vt[9].wrd = 5'd3; vt[9].wd = 32'hBB;
        vt[10] = mk(4'd0, 32'h11, 32'd9, 32'd0, 1'b1, 32'h11, 32'd9, 1'b0, 1);
        vt[10].rs = 5'd0; vt[10].ewe = 1; vt[10].erd = 5'd0; vt[10].ed = 32'hAA;
        vt[10].wwe = 1; vt[10].wrd = 5'd0; vt[10].wd = 32'hBB;
        vt[11] = mk(4'd0, 32'd1, 32'd9, 32'd0, 1'b1, 32'hBB, 32'd9, 1'b0, 1);
        vt[11].rs = 5'd4; vt[11].ewe = 1; vt[11].erd = 5'd5; vt[11].ed = 32'hAA;
        vt[11].wwe = 1; vt[11].wrd = 5'd4; vt[11].wd = 32'hBB;
        vt[12] = mk(4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 32'h78, 32'h77, 1'b0, 1);
        vt[12].rt = 5'd6; vt[12].ewe = 1; vt[12].erd = 5'd6; vt[12].ed = 32'h77;
        vt[13] = mk(4'd8, 32'h1234, 32'h10, 32'd0, 1'b0, 32'h12340, 32'h10, 1'b0, 33);
        vt[14] = mk(4'd9, 32'd100, 32'd7, 32'd0, 1'b0, 32'd14, 32'd7, 1'b0, 33);
        vt[15] = mk(4'd10, 32'd100, 32'd7, 32'd0, 1'b0, 32'd2, 32'd7, 1'b0, 33);
        vt[16] = mk(4'd9, 32'd9, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
        vt[17] = mk(4'd10, 32'd9, 32'd0, 32'd0, 1'b0, 32'd9, 32'd0, 1'b0, 33);
        vt[18] = mk(4'd12, 32'd5, 32'd6, 32'd0, 1'b0, 32'd0, 32'd6, 1'b1, 1);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        apply(vt[0]);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset out_result", out_result, 0);
        chk("reset out_store", out_store, 0);
        chk("reset out_dest", out_dest, 0);
        chk("reset out_ctrl", out_ctrl, 0);
        chk("reset out_illegal", out_illegal, 0);
        rst = 1'b0;

        // Directed vector table, out_ready held high.
        foreach (vt[i]) begin
            apply(vt[i]);
            in_valid = 1'b1;
            #1;
            chk($sformatf("vec%0d in_ready", i), in_ready, 1);
            tick();
            in_valid = 1'b0;
            in_rs_val = $urandom; in_rt_val = $urandom; exm_data = $urandom; wb_data = $urandom;
            n = 0;
            while (!out_valid && n < 40) begin
                tick();
                n++;
            end
            chk($sformatf("vec%0d latency", i), n + 1, vt[i].lat);
            chk($sformatf("vec%0d result", i), out_result, vt[i].er);
            chk($sformatf("vec%0d store", i), out_store, vt[i].es);
            chk($sformatf("vec%0d dest", i), out_dest, vt[i].rdst ? vt[i].rd : vt[i].rt);
            chk($sformatf("vec%0d illegal", i), out_illegal, vt[i].ill);
            chk($sformatf("vec%0d ctrl", i), out_ctrl, vt[i].ill ? 4'd0 : vt[i].ctrl);
        end
        tick();

        // MUL with in_valid held high: the following ADD waits for completion.
        apply(vt[13]); in_valid = 1'b1;
        tick();
        apply(vt[0]);
        bcnt = 0; n = 0;
        while (!out_valid && n < 40) begin
            if (busy) bcnt++;
            tick();
            n++;
        end
        chk("mul busy cycles", bcnt, 32);
        chk("mul result", out_result, 32'h12340);
        chk("mul in_ready after done", in_ready, 1);
        tick();
        chk("mul then add valid", out_valid, 1);
        chk("mul then add result", out_result, 32'd12);
        in_valid = 1'b0;
        tick();

        // Back-pressure: outputs hold, then consume + accept with no bubble.
        v = mk(4'd0, 32'h10, 32'd0, 32'h20, 1'b1, 32'h30, 32'd0, 1'b0, 1);
        apply(v); in_valid = 1'b1;
        tick();
        out_ready = 1'b0;
        v = mk(4'd1, 32'd10, 32'd3, 32'd0, 1'b0, 32'd7, 32'd3, 1'b0, 1);
        apply(v);
        repeat (5) begin
            tick();
            chk("bp result held", out_result, 32'h30);
            chk("bp valid held", out_valid, 1);
            chk("bp in_ready low", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp in_ready on consume", in_ready, 1);
        tick();
        chk("bp no bubble valid", out_valid, 1);
        chk("bp no bubble result", out_result, 32'd7);
        in_valid = 1'b0;
        tick();

        // Asynchronous reset in the middle of a DIVU.
        apply(vt[14]); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        chk("div busy before reset", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("async reset busy", busy, 0);
        chk("async reset out_valid", out_valid, 0);
        chk("async reset in_ready", in_ready, 1);
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
        v = mk(4'd0, 32'd1, 32'd0, 32'd1, 1'b1, 32'd2, 32'd0, 1'b0, 1);
        apply(v); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post reset add valid", out_valid, 1);
        chk("post reset add result", out_result, 32'd2);
        tick();

        // MULDIV_EN=0 instance: MUL opcode is single-cycle illegal.
        v = mk(4'd8, 32'd3, 32'd4, 32'd0, 1'b0, 32'd0, 32'd4, 1'b1, 1);
        v.ctrl = 4'b1111;
        apply(v); in_valid = 1'b1;
        #1;
        chk("nomd in_ready", d2_in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("nomd valid", d2_out_valid, 1);
        chk("nomd illegal", d2_out_illegal, 1);
        chk("nomd ctrl", d2_out_ctrl, 0);
        chk("nomd result", d2_out_result, 0);
        chk("nomd busy", d2_busy, 0);
        n = 0;
        while ((busy || out_valid) && n < 40) begin
            tick();
            n++;
        end

        // Random traffic against the reference model.
        for (int k = 0; k < 800; k++) begin
            r = $urandom_range(0, 15);
            if (r >= 8 && r <= 10 && $urandom_range(0, 3) != 0) r = $urandom_range(0, 7);
            in_op      = 4'(r);
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            in_rs_val  = $urandom;
            in_rt_val  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            in_imm     = $urandom;
            in_alu_src = 1'($urandom_range(0, 1));
            in_reg_dst = 1'($urandom_range(0, 1));
            in_rs      = 5'($urandom_range(0, 7));
            in_rt      = 5'($urandom_range(0, 7));
            in_rd      = 5'($urandom_range(0, 31));
            in_ctrl    = 4'($urandom_range(0, 15));
            exm_we     = 1'($urandom_range(0, 1));
            wb_we      = 1'($urandom_range(0, 1));
            exm_rd     = 5'($urandom_range(0, 7));
            wb_rd      = 5'($urandom_range(0, 7));
            exm_data   = $urandom;
            wb_data    = $urandom;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
